imem_prog: RTL
==============

# imem_prog

Parametrised, byte-addressed, little-endian instruction memory for the single-cycle RISC-V datapath, sitting between the PC/fetch logic and the decode stage. Contents are loaded at run time through a byte-serial programming port rather than hard-coded. After reset, a sweep fills the memory with NOPs. Fetches use a ready/valid handshake, and the instruction word and its decoded register fields are registered together from the same word.

## Interface
- ADDR_W, 32, width of fetch_addr
- DEPTH_BYTES, 256, memory size in bytes; power of two, ≥ 8
- NOP_WORD, 32'h00000013, fill/fault word (addi x0,x0,0)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- prog_start  in  1  clear load pointer, enter LOAD
- prog_valid  in  1  prog_data byte present
- prog_data  in  8  byte written at load pointer
- prog_done  in  1  leave LOAD
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address of instruction
- fetch_ready  out  1  fetch can be accepted
- fetch_valid  out  1  one-cycle pulse: instr/fields/fault updated
- instr  out  32  fetched word
- opcode  out  7  instr[6:0]
- rd  out  5  instr[11:7]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- fault  out  1  last fetch was misaligned or out of range
- load_count  out  $clog2(DEPTH_BYTES)+1  bytes written in current/last load

## Operation
- **States:**
  - INIT: NOP sweep, one 32-bit word per cycle, pointer 0 → DEPTH_BYTES/4−1.
  - IDLE: serve fetches.
  - LOAD: accept programming bytes.
- **Transitions:**
  - rst → INIT.
  - INIT, after the last word is written → IDLE.
  - IDLE & prog_start → LOAD.
  - LOAD & prog_done → IDLE.
  - LOAD & prog_start → LOAD, with pointer and load_count reset to 0.
  - prog_start and prog_done are ignored in INIT.
- **Loading:**
  - In LOAD, each prog_valid writes prog_data to mem[ptr]; ptr and load_count increment.
  - When load_count = DEPTH_BYTES, further bytes are dropped and load_count saturates.
  - prog_valid & prog_done in the same cycle: the byte is written, then the block exits LOAD.
  - Bytes not written keep their previous contents.
- **Fetching:**
  - fetch_ready = 1 only in IDLE (registered).
  - A fetch is accepted when fetch_req & fetch_ready at a rising edge.
  - If prog_start is in the same cycle, the fetch is still accepted and returns pre-load contents.
- **Read:** instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]}. opcode, rd, rs1 and rs2 are sliced from that same word in the same register update, never from the previous instr.
- **Fault:**
  - Condition: fetch_addr[1:0] ≠ 0, or fetch_addr ≥ DEPTH_BYTES (compare the full ADDR_W; no wrap).
  - Response: instr = NOP_WORD, fields decoded from NOP_WORD, fault = 1.
  - A non-faulting fetch clears fault.
- instr, fields and fault hold between fetches.
- The memory array is not reset; only control and output registers are. Contents become defined through INIT.

## Timing
- **Reset values:** fetch_ready 0, fetch_valid 0, instr 0, opcode/rd/rs1/rs2 0, fault 0, load_count 0, state INIT, pointer 0.
- **INIT duration:**
  - The first INIT write occurs at the first rising edge after rst deasserts.
  - fetch_ready goes to 1 after DEPTH_BYTES/4 edges (64 for the default).
- **Fetch latency:** request accepted at edge N → fetch_valid = 1 and outputs updated after edge N+1; fetch_valid falls after N+2 unless another request is accepted at N+1.
- **Throughput:** one fetch per cycle; back-to-back requests give a continuous fetch_valid.
- **LOAD:**
  - fetch_ready = 0 from the edge that enters LOAD.
  - fetch_ready returns to 1 at the edge that returns to IDLE.
  - A write is visible to a fetch accepted at the following edge or later.
- **Reset mid-operation:** rst asserted at any time (INIT, LOAD, fetch in flight) immediately forces reset values; the in-flight fetch is lost; INIT repeats and previously loaded contents are overwritten with NOP_WORD.

## Test plan
- Reset with defaults, hold fetch_req → fetch_ready low for 64 edges, then high; fetch 0x40 → instr 0x00000013, opcode 0x13, rd 0, rs1 0, rs2 0, fault 0.
- prog_start, then 8 bytes 83 20 02 01 13 01 11 00 with prog_done on the last → load_count 8; fetch 0 → 0x01022083, opcode 0x03, rd 1, rs1 4, rs2 16; fetch 4 → 0x00110113, rd 2, rs1 2, rs2 1.
- Fetch 0, 4, 8 on consecutive cycles after the load above → fetch_valid high 3 consecutive cycles; words 0x01022083, 0x00110113, 0x00000013 in order.
- Fetch 0x2, then 0x100 → fault 1, instr 0x00000013 both times; next fetch 0x0 → fault 0.
- Load 260 bytes → load_count saturates at 256, bytes 256–259 dropped; fetch 0xFC returns bytes 252–255; prog_valid & prog_done in the same cycle → byte written.
- Assert rst after 8 loaded bytes, mid-LOAD → all outputs at reset values; INIT takes 64 cycles; fetch 0 → 0x00000013.

Source files
------------

// File: rtl/imem_prog.sv
// imem_prog: byte-programmable instruction memory with a NOP fill after reset and a registered fetch port.
module imem_prog #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           prog_start,
  input  logic                           prog_valid,
  input  logic [7:0]                     prog_data,
  input  logic                           prog_done,
  input  logic                           fetch_req,
  input  logic [ADDR_W-1:0]              fetch_addr,
  output logic                           fetch_ready,
  output logic                           fetch_valid,
  output logic [31:0]                    instr,
  output logic [6:0]                     opcode,
  output logic [4:0]                     rd,
  output logic [4:0]                     rs1,
  output logic [4:0]                     rs2,
  output logic                           fault,
  output logic [$clog2(DEPTH_BYTES):0]   load_count
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;
  localparam int WW = AW - 2;
  typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;
  state_t          state_q, state_d;
  logic [WW-1:0]   init_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [31:0]     instr_q, rd_word;
  logic            rdy_q, req_q, pfault_q, valid_q, fault_q;
  logic            accept, addr_bad, wr_en;
  logic [7:0]      mem [DEPTH_BYTES];
  assign accept   = fetch_req && rdy_q;
  assign addr_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= ADDR_W'(DEPTH_BYTES));
  assign wr_en    = (state_q == LOAD) && prog_valid && !prog_start && (cnt_q < CW'(DEPTH_BYTES));
  // fetch address is word aligned and in range whenever this word is used
  assign rd_word  = {mem[{addr_q[AW-1:2], 2'd3}], mem[{addr_q[AW-1:2], 2'd2}],
                     mem[{addr_q[AW-1:2], 2'd1}], mem[{addr_q[AW-1:2], 2'd0}]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: state_d = (init_ptr_q == '1) ? IDLE : INIT;
      IDLE: begin
        state_d = prog_start ? LOAD : IDLE;
        cnt_d   = prog_start ? '0 : cnt_q;
      end
      LOAD: begin
        cnt_d   = prog_start ? '0 : wr_en ? cnt_q + CW'(1) : cnt_q;
        state_d = (prog_done && !prog_start) ? IDLE : LOAD;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      pfault_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= (state_q == INIT) ? init_ptr_q + WW'(1) : '0;
      cnt_q      <= cnt_d;
      rdy_q      <= (state_d == IDLE);
      req_q      <= accept;
      if (accept) begin
        addr_q   <= fetch_addr[AW-1:0];
        pfault_q <= addr_bad;
      end
      valid_q    <= req_q;
      if (req_q) begin
        instr_q <= pfault_q ? NOP_WORD : rd_word;
        fault_q <= pfault_q;
      end
    end
  end
  // storage is deliberately left out of reset; the INIT sweep defines it
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      for (int i = 0; i < 4; i++) mem[{init_ptr_q, 2'(i)}] <= NOP_WORD[8*i +: 8];
    else if (wr_en)
      mem[cnt_q[AW-1:0]] <= prog_data;
  end
  assign fetch_ready = rdy_q;
  assign fetch_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign fault       = fault_q;
  assign load_count  = cnt_q;
endmodule
